// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared ideal_mem data port
//
// Ports:
//   clk, resetn (async active-low), mips_rst (masks CPU requests/acks)
//   cpu_*/axi_*/dma_* : req/we/addr/wdata in, one-cycle ack + rdata out
//   mem_*             : ideal_mem port-2 read, write port, read data in
//   busy              : FSM not in IDLE
//   grant_id          : 0=CPU 1=AXI 2=DMA 3=none
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mips_rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-3:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  axi_req,
  input  logic                  axi_we,
  input  logic [ADDR_WIDTH-3:0] axi_addr,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_ack,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-3:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-3:0] mem_raddr,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-3:0] mem_waddr,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  state_t                state;
  logic [1:0]            last_gnt;
  logic                  cur_we;
  logic [2:0]            wait_cnt;
  logic                  cpu_ack_r;
  logic [2:0]            elig;
  logic [1:0]            pick_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-3:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign elig = {dma_req, axi_req, cpu_req & ~mips_rst};

  // Ack is also masked combinationally so a mips_rst raised during RESP
  // still hides the pulse from the CPU.
  assign cpu_ack = cpu_ack_r & ~mips_rst;

  // First eligible requester in cyclic order after last_gnt.
  always_comb begin
    pick_id = 2'd3;
    case (last_gnt)
      2'd0: begin
        if (elig[1])      pick_id = 2'd1;
        else if (elig[2]) pick_id = 2'd2;
        else if (elig[0]) pick_id = 2'd0;
      end
      2'd1: begin
        if (elig[2])      pick_id = 2'd2;
        else if (elig[0]) pick_id = 2'd0;
        else if (elig[1]) pick_id = 2'd1;
      end
      default: begin
        if (elig[0])      pick_id = 2'd0;
        else if (elig[1]) pick_id = 2'd1;
        else if (elig[2]) pick_id = 2'd2;
      end
    endcase
  end

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    case (pick_id)
      2'd1: begin
        sel_we    = axi_we;
        sel_addr  = axi_addr;
        sel_wdata = axi_wdata;
      end
      2'd2: begin
        sel_we    = dma_we;
        sel_addr  = dma_addr;
        sel_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      last_gnt  <= 2'd2;
      grant_id  <= 2'd3;
      busy      <= 1'b0;
      cur_we    <= 1'b0;
      wait_cnt  <= 3'd0;
      cpu_ack_r <= 1'b0;
      axi_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      axi_rdata <= '0;
      dma_rdata <= '0;
      mem_rden  <= 1'b0;
      mem_wren  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack_r <= 1'b0;
      axi_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_id != 2'd3) begin
            grant_id <= pick_id;
            last_gnt <= pick_id;
            cur_we   <= sel_we;
            busy     <= 1'b1;
            state    <= ACCESS;
            // Memory strobes are registered here so they are live in ACCESS.
            if (sel_we) begin
              mem_wren  <= 1'b1;
              mem_waddr <= sel_addr;
              mem_wdata <= sel_wdata;
            end else begin
              mem_rden  <= 1'b1;
              mem_raddr <= sel_addr;
            end
          end
        end
        ACCESS: begin
          mem_wren  <= 1'b0;
          mem_rden  <= 1'b0;
          mem_waddr <= '0;
          mem_raddr <= '0;
          mem_wdata <= '0;
          if (cur_we) begin
            state <= RESP;
            case (grant_id)
              2'd0:    cpu_ack_r <= ~mips_rst;
              2'd1:    axi_ack   <= 1'b1;
              2'd2:    dma_ack   <= 1'b1;
              default: ;
            endcase
          end else begin
            wait_cnt <= 3'(MEM_RD_LATENCY);
            state    <= RDWAIT;
          end
        end
        RDWAIT: begin
          // Count 1 marks the cycle in which mem_rdata is valid.
          if (wait_cnt == 3'd1) begin
            state <= RESP;
            case (grant_id)
              2'd0: begin
                if (!mips_rst) begin
                  cpu_ack_r <= 1'b1;
                  cpu_rdata <= mem_rdata;
                end
              end
              2'd1: begin
                axi_ack   <= 1'b1;
                axi_rdata <= mem_rdata;
              end
              2'd2: begin
                dma_ack   <= 1'b1;
                dma_rdata <= mem_rdata;
              end
              default: ;
            endcase
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          grant_id <= 2'd3;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          mips_rst;
  logic          cpu_req, cpu_we, axi_req, axi_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, axi_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, axi_wdata, dma_wdata;
  logic          cpu_ack, axi_ack, dma_ack;
  logic [DW-1:0] cpu_rdata, axi_rdata, dma_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_rden, mem_wren;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;
  logic [1:0]    grant_id;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt0 = 0, ack_cnt1 = 0, ack_cnt2 = 0, rden_cnt = 0;
  int ack_log[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(DW), .MEM_RD_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .mips_rst(mips_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .axi_req(axi_req), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_ack(axi_ack), .axi_rdata(axi_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_raddr(mem_raddr), .mem_rden(mem_rden), .mem_waddr(mem_waddr),
    .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  // Memory model: write array, reads return a fixed function of the address
  // valid only in the one cycle RL edges after mem_rden is sampled.
  logic [DW-1:0] wmem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RL-1];
  logic          rd_vld  [0:RL-1];

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    case (a)
      14'h2A0: rd_val = 32'h1234_5678;
      14'h004: rd_val = 32'hA5A5_0004;
      default: rd_val = 32'h5A00_0000 | 32'(a);
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_wren) wmem[mem_waddr] <= mem_wdata;
    rd_pipe[0] <= rd_val(mem_raddr);
    rd_vld[0]  <= mem_rden;
    for (int i = 1; i < RL; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
  end
  assign mem_rdata = rd_vld[RL-1] ? rd_pipe[RL-1] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (cpu_ack)  begin ack_cnt0++; ack_log.push_back(0); end
    if (axi_ack)  begin ack_cnt1++; ack_log.push_back(1); end
    if (dma_ack)  begin ack_cnt2++; ack_log.push_back(2); end
    if (mem_rden) rden_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acks"},  32'({dma_ack, axi_ack, cpu_ack}), 32'd0);
    check({tag, "_rden"},  32'(mem_rden), 32'd0);
    check({tag, "_wren"},  32'(mem_wren), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_gnt"},   32'(grant_id), 32'd3);
    check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_crd"},   cpu_rdata, 32'd0);
    check({tag, "_ard"},   axi_rdata, 32'd0);
    check({tag, "_drd"},   dma_rdata, 32'd0);
  endtask

  // Cycle index (0 = first negedge after call) of the first ack from 'who'.
  task automatic wait_ack(input int who, input int max_cyc, output int cyc, output logic [DW-1:0] rd);
    logic [2:0] a;
    cyc = -1;
    rd  = '0;
    for (int n = 0; n <= max_cyc; n++) begin
      @(negedge clk);
      a = {dma_ack, axi_ack, cpu_ack};
      if (a[who]) begin
        cyc = n;
        rd  = (who == 0) ? cpu_rdata : (who == 1) ? axi_rdata : dma_rdata;
        break;
      end
    end
  endtask

  // Each requester drops req in the cycle after its own ack.
  task automatic serve(input int n_acks, input int budget);
    logic [2:0] d;
    for (int n = 0; n < budget && ack_log.size() < n_acks; n++) begin
      @(negedge clk);
      d = {dma_ack, axi_ack, cpu_ack};
      @(posedge clk); #1;
      if (d[0]) cpu_req = 1'b0;
      if (d[1]) axi_req = 1'b0;
      if (d[2]) dma_req = 1'b0;
    end
    check("serve_count", 32'(ack_log.size()), 32'(n_acks));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int            cyc, idle_n, s0, s1, s2, sr;
    logic [DW-1:0] rd;

    // Reset with random inputs
    resetn    = 1'b0;
    mips_rst  = 1'($urandom);
    cpu_req   = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 14'($urandom); cpu_wdata = $urandom;
    axi_req   = 1'($urandom); axi_we = 1'($urandom); axi_addr = 14'($urandom); axi_wdata = $urandom;
    dma_req   = 1'($urandom); dma_we = 1'($urandom); dma_addr = 14'($urandom); dma_wdata = $urandom;
    #23;
    check_reset_outputs("rst");
    mips_rst = 1'b0;
    cpu_req = 1'b0; axi_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1;

    // CPU write right after release
    resetn = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h010; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("w_c0_wren", 32'(mem_wren), 32'd0);
    @(negedge clk);
    check("w_c1_wren",  32'(mem_wren), 32'd1);
    check("w_c1_waddr", 32'(mem_waddr), 32'h010);
    check("w_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("w_c1_gnt",   32'(grant_id), 32'd0);
    @(negedge clk);
    check("w_c2_ack",   32'(cpu_ack), 32'd1);
    check("w_c2_waddr", 32'(mem_waddr), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("w_c3_busy", 32'(busy), 32'd0);
    check("w_c3_gnt",  32'(grant_id), 32'd3);
    check("w_mem",     wmem[14'h010], 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // DMA read, latency 3
    s0 = ack_cnt0; s1 = ack_cnt1; s2 = ack_cnt2; sr = rden_cnt;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h2A0;
    wait_ack(2, 10, cyc, rd);
    check("rd_ack_cyc", 32'(cyc), 32'd5);
    check("rd_data",    rd, 32'h1234_5678);
    @(posedge clk); #1;
    dma_req = 1'b0;
    check("rd_rden_cycles", 32'(rden_cnt - sr), 32'd1);
    check("rd_other_acks",  32'((ack_cnt0 - s0) + (ack_cnt1 - s1)), 32'd0);
    check("rd_dma_acks",    32'(ack_cnt2 - s2), 32'd1);

    // Round robin: all three write
    ack_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h021; cpu_wdata = 32'h1111_1111;
    axi_req = 1'b1; axi_we = 1'b1; axi_addr = 14'h022; axi_wdata = 32'h2222_2222;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h023; dma_wdata = 32'h3333_3333;
    serve(3, 40);
    check("rr1_0", 32'(ack_log[0]), 32'd0);
    check("rr1_1", 32'(ack_log[1]), 32'd1);
    check("rr1_2", 32'(ack_log[2]), 32'd2);
    check("rr1_m1", wmem[14'h021], 32'h1111_1111);
    check("rr1_m2", wmem[14'h022], 32'h2222_2222);
    check("rr1_m3", wmem[14'h023], 32'h3333_3333);

    // Round robin again with reads: CPU first after DMA
    ack_log.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h030;
    axi_req = 1'b1; axi_we = 1'b0; axi_addr = 14'h031;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h032;
    serve(3, 60);
    check("rr2_0", 32'(ack_log[0]), 32'd0);
    check("rr2_1", 32'(ack_log[1]), 32'd1);
    check("rr2_2", 32'(ack_log[2]), 32'd2);
    check("rr2_crd", cpu_rdata, 32'h5A00_0030);
    check("rr2_ard", axi_rdata, 32'h5A00_0031);
    check("rr2_drd", dma_rdata, 32'h5A00_0032);

    // mips_rst masks CPU
    ack_log.delete();
    mips_rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h005; cpu_wdata = 32'h0BAD_CAFE;
    axi_req = 1'b1; axi_we = 1'b0; axi_addr = 14'h004;
    serve(1, 20);
    check("mr_first", 32'(ack_log[0]), 32'd1);
    check("mr_ard",   axi_rdata, 32'hA5A5_0004);
    s0 = ack_cnt0;
    repeat (8) @(negedge clk);
    check("mr_idle_busy", 32'(busy), 32'd0);
    check("mr_idle_gnt",  32'(grant_id), 32'd3);
    check("mr_no_cpu",    32'(ack_cnt0 - s0), 32'd0);
    @(posedge clk); #1;
    mips_rst = 1'b0;
    wait_ack(0, 8, cyc, rd);
    check("mr_cpu_cyc", 32'(cyc), 32'd2);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("mr_cpu_mem", wmem[14'h005], 32'h0BAD_CAFE);

    // mips_rst during a CPU read
    s0 = ack_cnt0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h008;
    @(negedge clk);
    @(negedge clk);
    check("mm_gnt",  32'(grant_id), 32'd0);
    check("mm_rden", 32'(mem_rden), 32'd1);
    @(posedge clk); #1;
    ack_log.delete();
    mips_rst = 1'b1; cpu_req = 1'b0;
    axi_req = 1'b1; axi_we = 1'b0; axi_addr = 14'h00C;
    idle_n = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!busy) begin idle_n = n; break; end
    end
    check("mm_idle_n", 32'(idle_n), 32'd4);
    wait_ack(1, 10, cyc, rd);
    check("mm_axi_cyc", 32'(cyc), 32'd4);
    check("mm_axi_rd",  rd, 32'h5A00_000C);
    @(posedge clk); #1;
    axi_req = 1'b0; mips_rst = 1'b0;
    check("mm_no_cpu_ack", 32'(ack_cnt0 - s0), 32'd0);
    check("mm_crd_kept",   cpu_rdata, 32'h5A00_0030);
    check("mm_log_n",      32'(ack_log.size()), 32'd1);
    check("mm_log_0",      32'(ack_log[0]), 32'd1);

    // Async reset mid-read
    s2 = ack_cnt2;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h2A0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    check("ar_busy_before", 32'(busy), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("ar");
    dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    axi_req = 1'b1; axi_we = 1'b1; axi_addr = 14'h007; axi_wdata = 32'hCAFE_F00D;
    wait_ack(1, 8, cyc, rd);
    check("ar_axi_cyc", 32'(cyc), 32'd2);
    @(posedge clk); #1;
    axi_req = 1'b0;
    check("ar_mem",     wmem[14'h007], 32'hCAFE_F00D);
    check("ar_no_dma",  32'(ack_cnt2 - s2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequential arbiter for the shared data port (port 2) of ideal_mem.
- Three requesters share the port: the MIPS CPU data port, the AXI-Lite host interface and the DMA engine.
- Grants are round-robin, one transaction at a time. The winning address and data are registered, the memory is driven, and a single-cycle ack plus read data goes back to the winner.
- The block replaces the combinational contention scheme that returned 0xFFFFFFFF to a losing requester: a losing requester now waits instead.

Parameters:
- ADDR_WIDTH, 16, byte-address width; word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32, data width.
- MEM_RD_LATENCY, 1, cycles from mem_rden sampled to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- mips_rst  in  1  CPU held in reset; masks CPU requests
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_WIDTH-2  word address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack=1
- axi_req, axi_we, axi_addr, axi_wdata, axi_ack, axi_rdata  same directions and widths as the cpu_* ports  AXI-Lite requester
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same directions and widths as the cpu_* ports  DMA requester
- mem_raddr  out  ADDR_WIDTH-2  ideal_mem Raddr2
- mem_rden  out  1  ideal_mem Rden2
- mem_waddr  out  ADDR_WIDTH-2  ideal_mem Waddr
- mem_wren  out  1  ideal_mem Wren
- mem_wdata  out  DATA_WIDTH  ideal_mem Wdata
- mem_rdata  in  DATA_WIDTH  ideal_mem Rdata2
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  owner of the current transaction: 0=CPU, 1=AXI, 2=DMA, 3=none

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous, active-low.
- Reset values:
  - all acks, mem_rden, mem_wren and busy are 0;
  - all rdata outputs, mem addresses and mem_wdata are 0;
  - grant_id = 3;
  - state = IDLE;
  - round-robin pointer last_gnt = 2 (DMA), so the CPU has first priority after reset.
- Eligibility: cpu_req is masked by ~mips_rst. axi_req and dma_req are always eligible.
- FSM states: IDLE, ACCESS, RDWAIT, RESP.
- IDLE:
  - If any requester is eligible, pick the first one in cyclic order after last_gnt (last_gnt 0 gives AXI, DMA, CPU).
  - Latch its id, we, addr and wdata, update last_gnt, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Write: mem_wren=1, mem_waddr and mem_wdata = latched values, then go to RESP.
  - Read: mem_rden=1, mem_raddr = latched addr, load the wait counter with MEM_RD_LATENCY, then go to RDWAIT.
- RDWAIT:
  - Decrement the counter each cycle.
  - When it reaches 1, register mem_rdata into the winner's rdata register and go to RESP.
- RESP (exactly 1 cycle): the winner's ack = 1 and its rdata holds the captured value; then return to IDLE.
- Latency from request first sampled in IDLE (cycle 0) to ack:
  - write: ack in cycle 2;
  - read: ack in cycle 2+MEM_RD_LATENCY.
- Turnaround: there is always one IDLE cycle between transactions, so the maximum rate is one transaction per 3 cycles (write).
- Handshake rules:
  - A requester must hold req, we, addr and wdata stable until it samples ack.
  - It must deassert req in the cycle after ack or it is re-arbitrated.
  - Inputs are latched in IDLE, so changes after the grant have no effect on the transaction.
- Output masking:
  - mem_raddr, mem_waddr and mem_wdata are 0 whenever their enable is low.
  - rdata for a non-winner and for write transactions keeps its previous value; a write ack does not update rdata.
- Simultaneous requests: resolved only by last_gnt. Any eligible requester is granted within 3 arbitration rounds (no starvation).
- mips_rst asserted while a CPU transaction is in ACCESS, RDWAIT or RESP:
  - the memory access completes unchanged;
  - cpu_ack is suppressed (cpu_rdata not updated);
  - the FSM returns to IDLE normally.
- resetn asserted mid-transaction: immediate return to reset values. A write already sampled by memory is not undone.
- Addresses are passed through unchanged. Peripheral decode (DMA registers, interrupt mask) stays downstream.

Test Plan:
- Reset: resetn=0 with random inputs -> every output at its reset value and grant_id=3. After release, cpu_req=1, cpu_we=1, cpu_addr=0x010, cpu_wdata=0xDEADBEEF -> mem_wren=1, mem_waddr=0x010 in cycle 1; cpu_ack in cycle 2.
- Read latency: MEM_RD_LATENCY=3, dma read of addr 0x2A0 with memory returning 0x12345678 -> mem_rden high for exactly 1 cycle, dma_ack in cycle 5, dma_rdata=0x12345678, no other ack asserted.
- Round-robin: cpu_req, axi_req and dma_req held high, each dropped one cycle after its own ack -> grant order CPU, AXI, DMA. Then re-assert all three with last_gnt=2 -> CPU is granted first again.
- mips_rst masking: mips_rst=1 with cpu_req=1 and axi_req=1 (read 0x004) -> only AXI is granted; CPU is never acked until mips_rst=0, then granted on the next IDLE.
- mips_rst mid-transaction: CPU read in RDWAIT, then mips_rst pulses -> no cpu_ack, FSM reaches IDLE within MEM_RD_LATENCY+1 cycles, a pending axi_req is served next.
- Async reset mid-read: resetn low in RDWAIT -> outputs return to reset values within the same cycle (no clock edge needed), no ack is issued, and a fresh request after release completes normally.
